sub8_serial: RTL and testbench

Bit-serial 8-bit subtractor computing in1 - in2 (- borrow_in when enabled), LSB first, one bit per clock.
Sits alongside the combinational adders in the octet math group as the area-cheap inverse operation: one full-subtractor cell plus shift registers instead of an 8-cell chain.
Start/done handshake. Produces difference, borrow, zero and signed-overflow flags.

---
 rtl/sub8_serial.sv | 116 +++++++++++
 tb/tb_sub8_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sub8_serial.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first.
// Optional chained borrow input is enabled by defining SUB8_BORROW_IN_EN.
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
`ifdef SUB8_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;

  logic             w_bin;
  logic             w_dbit;
  logic             w_bnext;
  logic [WIDTH-1:0] w_diff;

`ifdef SUB8_BORROW_IN_EN
  assign w_bin = borrow_in;
`else
  assign w_bin = 1'b0;
`endif

  assign w_dbit  = r_a[0] ^ r_b[0] ^ r_br;
  assign w_bnext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  // The result word as it stands after this cycle's bit enters at the MSB.
  assign w_diff  = {w_dbit, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= in1;
            r_b     <= in2;
            r_br    <= w_bin;
            r_cnt   <= '0;
            r_a_msb <= in1[WIDTH-1];
            r_b_msb <= in2[WIDTH-1];
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_br  <= w_bnext;
          r_res <= w_diff[WIDTH-1:1];
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          // Last bit: publish the completed word and flags together.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state  <= DONE;
            done     <= 1'b1;
            diff     <= w_diff;
            borrow   <= w_bnext;
            zero     <= (w_diff == '0);
            overflow <= (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub8_serial.sv
// Directed self-checking bench for sub8_serial; expected values are hand-computed.
// Borrow-in vectors run only when SUB8_BORROW_IN_EN is defined.
module tb_sub8_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow;
  logic       zero;
  logic       overflow;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int cycles;
  int doneCount;
  int firstDone;
  int secondDone;

  sub8_serial #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
`ifdef SUB8_BORROW_IN_EN
    .borrow_in(bin),
`endif
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents an operation on a negedge; returns at the negedge right after the accepting edge,
  // with in1/in2 scrambled to show they are not re-sampled while busy.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bi);
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    bin   = bi;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    in1   = 8'hA5;
    in2   = 8'h3C;
    bin   = ~bi;
  endtask

  task automatic waitDone(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] expDiff, input logic expBorrow, input logic expZero,
                       input logic expOvf);
    int n;
    applyStimulus(a, b, bi);
    checkOutput({tag, ".busyEarly"}, {7'd0, busy}, 8'h01);
    waitDone(n);
    checkOutput({tag, ".latency"}, n[7:0], 8'd9);
    checkOutput({tag, ".diff"}, diff, expDiff);
    checkOutput({tag, ".borrow"}, {7'd0, borrow}, {7'd0, expBorrow});
    checkOutput({tag, ".zero"}, {7'd0, zero}, {7'd0, expZero});
    checkOutput({tag, ".overflow"}, {7'd0, overflow}, {7'd0, expOvf});
    @(negedge clk);
    checkOutput({tag, ".doneFall"}, {7'd0, done}, 8'h00);
    checkOutput({tag, ".busyFall"}, {7'd0, busy}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in1   = 8'h00;
    in2   = 8'h00;
    bin   = 1'b0;
    #12;
    checkOutput("reset.busy", {7'd0, busy}, 8'h00);
    checkOutput("reset.done", {7'd0, done}, 8'h00);
    checkOutput("reset.diff", diff, 8'h00);
    checkOutput("reset.flags", {5'd0, borrow, zero, overflow}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("sub50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    runOp("sub20_50", 8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
    runOp("sub00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    runOp("sub7F_7F", 8'h7F, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    runOp("sub80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);

    // Starts at edges E+3 and E+9 land in SHIFT and DONE and must be dropped.
    applyStimulus(8'h50, 8'h20, 1'b0);
    doneCount = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) doneCount++;
      if (c == 3 || c == 9) begin
        start = 1'b1;
        in1   = 8'h01;
        in2   = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("ignore.doneCount", doneCount[7:0], 8'd1);
    checkOutput("ignore.diff", diff, 8'h30);
    checkOutput("ignore.busy", {7'd0, busy}, 8'h00);

    // Start held high: second accept one cycle after done falls.
    @(negedge clk);
    start = 1'b1;
    in1   = 8'h50;
    in2   = 8'h20;
    @(posedge clk);
    @(negedge clk);
    in1 = 8'h09;
    in2 = 8'h04;
    cycles = 1;
    firstDone = 0;
    secondDone = 0;
    while (secondDone == 0 && cycles < 40) begin
      if (done && firstDone == 0) firstDone = cycles;
      else if (done && firstDone != 0) secondDone = cycles;
      if (secondDone == 0) begin
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
    checkOutput("held.firstDone", firstDone[7:0], 8'd9);
    checkOutput("held.period", 8'(secondDone - firstDone), 8'd10);
    checkOutput("held.diff", diff, 8'h05);

    // Reset in the middle of an operation aborts it without a done pulse.
    @(negedge clk);
    @(negedge clk);
    applyStimulus(8'h50, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", {7'd0, busy}, 8'h00);
    checkOutput("abort.diff", diff, 8'h00);
    checkOutput("abort.flags", {5'd0, borrow, zero, overflow}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("abort.noDone", doneCount[7:0], 8'd0);
    runOp("sub05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

`ifdef SUB8_BORROW_IN_EN
    runOp("bin10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    runOp("bin00_00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
